// File: rtl/mole_level_if.sv
// Handshake bundle between the game-flow sequencer and its user.
// The master drives player/start inputs; the slave (sequencer) drives game status.
interface mole_level_if;
    logic        start;
    logic        hit;
    logic        miss;
    logic        game;
    logic [27:0] speed;
    logic [2:0]  level;
    logic [7:0]  time_left;
    logic [1:0]  countdown;
    logic        done;

    modport master (
        output start, hit, miss,
        input  game, speed, level, time_left, countdown, done
    );

    modport slave (
        input  start, hit, miss,
        output game, speed, level, time_left, countdown, done
    );
endinterface

// File: rtl/mole_level_controller.sv
// Game-flow sequencer for the three-mole whack-a-mole game: start countdown,
// timed play session, hit-driven level progression and HEX display values.
module mole_level_controller #(
    parameter int CLK_PER_SEC       = 50000000,
    parameter int COUNTDOWN_SECONDS = 3,
    parameter int GAME_SECONDS      = 30,
    parameter int HITS_PER_LEVEL    = 5,
    parameter int NUM_LEVELS        = 4,
    parameter int BASE_SPEED        = 99999999,
    parameter int SPEED_STEP        = 20000000
) (
    input  logic          clock,
    input  logic          resetn,
    mole_level_if.slave   bus
);

    localparam int SEC_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;

    localparam logic [SEC_W-1:0] SEC_MAX    = SEC_W'(CLK_PER_SEC - 1);
    localparam logic [1:0]       CD_INIT    = 2'(COUNTDOWN_SECONDS);
    localparam logic [7:0]       TIME_INIT  = 8'(GAME_SECONDS);
    localparam logic [3:0]       HITS_MAX   = 4'(HITS_PER_LEVEL);
    localparam logic [3:0]       HITS_LAST  = 4'(HITS_PER_LEVEL - 1);
    localparam logic [2:0]       LEVEL_TOP  = 3'(NUM_LEVELS - 1);
    localparam logic [27:0]      SPEED_INIT = 28'(BASE_SPEED);
    localparam logic [27:0]      SPEED_DEC  = 28'(SPEED_STEP);

    typedef enum logic [2:0] {
        IDLE,
        COUNTDOWN,
        PLAY,
        LEVEL_UP,
        OVER
    } state_t;

    state_t            state, state_nxt;
    logic [SEC_W-1:0]  sec_cnt, sec_cnt_nxt;
    logic [3:0]        hits, hits_nxt;
    logic              start_q;
    logic              start_edge;
    logic              tick;

    logic              game_r, game_nxt;
    logic              done_r, done_nxt;
    logic [27:0]       speed_r, speed_nxt;
    logic [2:0]        level_r, level_nxt;
    logic [7:0]        time_r, time_nxt;
    logic [1:0]        cd_r, cd_nxt;

    // Net hit count grows by one but never past the per-level target.
    function automatic logic [3:0] hits_inc(input logic [3:0] h);
        return (h >= HITS_MAX) ? HITS_MAX : h + 4'd1;
    endfunction

    // A miss takes one hit back, floored at zero.
    function automatic logic [3:0] hits_dec(input logic [3:0] h);
        return (h == 4'd0) ? 4'd0 : h - 4'd1;
    endfunction

    assign start_edge = bus.start & ~start_q;
    assign tick       = (sec_cnt == SEC_MAX);

    assign bus.game      = game_r;
    assign bus.done      = done_r;
    assign bus.speed     = speed_r;
    assign bus.level     = level_r;
    assign bus.time_left = time_r;
    assign bus.countdown = cd_r;

    // Next-state and next-output logic for the game sequencer.
    always_comb begin
        state_nxt   = state;
        sec_cnt_nxt = sec_cnt;
        hits_nxt    = hits;
        speed_nxt   = speed_r;
        level_nxt   = level_r;
        time_nxt    = time_r;
        cd_nxt      = cd_r;
        done_nxt    = done_r;

        case (state)
            IDLE, OVER: begin
                sec_cnt_nxt = '0;
                if (start_edge) begin
                    state_nxt = COUNTDOWN;
                    cd_nxt    = CD_INIT;
                    level_nxt = 3'd0;
                    speed_nxt = SPEED_INIT;
                    done_nxt  = 1'b0;
                end
            end
            COUNTDOWN: begin
                sec_cnt_nxt = tick ? '0 : sec_cnt + 1'b1;
                if (tick) begin
                    if (cd_r > 2'd1) begin
                        cd_nxt = cd_r - 2'd1;
                    end else begin
                        state_nxt = PLAY;
                        cd_nxt    = 2'd0;
                        time_nxt  = TIME_INIT;
                        hits_nxt  = 4'd0;
                    end
                end
            end
            PLAY: begin
                sec_cnt_nxt = tick ? '0 : sec_cnt + 1'b1;
                if (tick && time_r == 8'd1) begin
                    // Session end wins over any simultaneous hit or miss.
                    state_nxt = OVER;
                    time_nxt  = 8'd0;
                    done_nxt  = 1'b1;
                end else begin
                    if (tick) begin
                        time_nxt = time_r - 8'd1;
                    end
                    if (bus.hit) begin
                        if (hits == HITS_LAST && level_r < LEVEL_TOP) begin
                            state_nxt = LEVEL_UP;
                            level_nxt = level_r + 3'd1;
                            speed_nxt = speed_r - SPEED_DEC;
                            hits_nxt  = 4'd0;
                        end else begin
                            hits_nxt = hits_inc(hits);
                        end
                    end else if (bus.miss) begin
                        hits_nxt = hits_dec(hits);
                    end
                end
            end
            LEVEL_UP: begin
                // One game=0 cycle lets the display restart its round; the
                // second ticker is frozen so this cycle is not charged as play.
                state_nxt = PLAY;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        game_nxt = (state_nxt == PLAY);
    end

    // State, counters and registered outputs, with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state   <= IDLE;
            sec_cnt <= '0;
            hits    <= 4'd0;
            start_q <= 1'b0;
            game_r  <= 1'b0;
            done_r  <= 1'b0;
            speed_r <= SPEED_INIT;
            level_r <= 3'd0;
            time_r  <= TIME_INIT;
            cd_r    <= 2'd0;
        end else begin
            state   <= state_nxt;
            sec_cnt <= sec_cnt_nxt;
            hits    <= hits_nxt;
            start_q <= bus.start;
            game_r  <= game_nxt;
            done_r  <= done_nxt;
            speed_r <= speed_nxt;
            level_r <= level_nxt;
            time_r  <= time_nxt;
            cd_r    <= cd_nxt;
        end
    end

endmodule

// File: tb/tb_mole_level_controller.sv
// Scoreboard bench for mole_level_controller: stimulus pushes the expected
// post-edge outputs from a timeline model; a monitor pops and compares.
module tb_mole_level_controller;

    localparam int CPS  = 4;
    localparam int CDS  = 3;
    localparam int GS   = 5;
    localparam int HPL  = 2;
    localparam int NL   = 3;
    localparam int BASE = 100;
    localparam int STEP = 30;

    localparam int PH_IDLE = 0;
    localparam int PH_CD   = 1;
    localparam int PH_PLAY = 2;
    localparam int PH_LVL  = 3;
    localparam int PH_OVER = 4;

    typedef struct {
        logic        game;
        logic [27:0] speed;
        logic [2:0]  level;
        logic [7:0]  time_left;
        logic [1:0]  countdown;
        logic        done;
    } exp_t;

    logic clock = 1'b0;
    logic resetn;
    mole_level_if bus();

    mole_level_controller #(
        .CLK_PER_SEC(CPS), .COUNTDOWN_SECONDS(CDS), .GAME_SECONDS(GS),
        .HITS_PER_LEVEL(HPL), .NUM_LEVELS(NL), .BASE_SPEED(BASE), .SPEED_STEP(STEP)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cycle       = 0;

    // Model: phase plus elapsed play/countdown cycles; displayed values are
    // derived arithmetically from elapsed time.
    int m_phase, m_elapsed, m_net, m_lvl, m_tl, m_done;
    bit m_prev;
    bit cur_start;

    task automatic model_step(input bit r, input bit s, input bit h, input bit m);
        bit   st_rise;
        exp_t e;
        if (!r) begin
            m_phase = PH_IDLE; m_elapsed = 0; m_net = 0; m_lvl = 0;
            m_tl = GS; m_done = 0; m_prev = 1'b0;
        end else begin
            st_rise = s && !m_prev;
            m_prev  = s;
            case (m_phase)
                PH_IDLE, PH_OVER: begin
                    if (st_rise) begin
                        m_phase = PH_CD; m_elapsed = 0; m_lvl = 0; m_done = 0;
                    end
                end
                PH_CD: begin
                    m_elapsed++;
                    if (m_elapsed == CDS * CPS) begin
                        m_phase = PH_PLAY; m_elapsed = 0; m_net = 0; m_tl = GS;
                    end
                end
                PH_PLAY: begin
                    m_elapsed++;
                    if (m_elapsed == GS * CPS) begin
                        m_phase = PH_OVER; m_tl = 0; m_done = 1;
                    end else begin
                        m_tl = GS - m_elapsed / CPS;
                        if (h) begin
                            if (m_net + 1 >= HPL && m_lvl < NL - 1) begin
                                m_lvl++; m_net = 0; m_phase = PH_LVL;
                            end else begin
                                m_net = (m_net + 1 > HPL) ? HPL : m_net + 1;
                            end
                        end else if (m) begin
                            m_net = (m_net > 0) ? m_net - 1 : 0;
                        end
                    end
                end
                PH_LVL: m_phase = PH_PLAY;
                default: m_phase = PH_IDLE;
            endcase
        end
        e.game      = (m_phase == PH_PLAY);
        e.speed     = 28'(BASE - m_lvl * STEP);
        e.level     = 3'(m_lvl);
        e.time_left = 8'(m_tl);
        e.countdown = (m_phase == PH_CD) ? 2'(CDS - m_elapsed / CPS) : 2'd0;
        e.done      = (m_done != 0);
        exp_q.push_back(e);
    endtask

    task automatic step(input bit r, input bit s, input bit h, input bit m);
        @(negedge clock);
        resetn    = r;
        bus.start = s;
        bus.hit   = h;
        bus.miss  = m;
        cur_start = s;
        model_step(r, s, h, m);
    endtask

    task automatic run_until(input int ph, input int limit);
        int n = 0;
        while (m_phase != ph && n < limit) begin
            step(1'b1, cur_start, 1'b0, 1'b0);
            n++;
        end
        if (m_phase != ph) begin
            vectors++;
            miscompares++;
            $display("FAIL run_until: reached phase %0d, required phase %0d", m_phase, ph);
        end
    endtask

    task automatic restart_to_play();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        run_until(PH_PLAY, 40);
    endtask

    // Monitor: compare the DUT against each expected entry just after its edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            cycle++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (bus.game !== e.game || bus.speed !== e.speed || bus.level !== e.level ||
                    bus.time_left !== e.time_left || bus.countdown !== e.countdown ||
                    bus.done !== e.done) begin
                    miscompares++;
                    $display("FAIL outputs cycle %0d: got game=%0b speed=%0d level=%0d time_left=%0d countdown=%0d done=%0b, required game=%0b speed=%0d level=%0d time_left=%0d countdown=%0d done=%0b",
                             cycle, bus.game, bus.speed, bus.level, bus.time_left, bus.countdown, bus.done,
                             e.game, e.speed, e.level, e.time_left, e.countdown, e.done);
                end
            end
        end
    end

    // Stimulus: directed game flows followed by randomized sessions.
    initial begin
        int n;
        resetn = 1'b0; bus.start = 1'b0; bus.hit = 1'b0; bus.miss = 1'b0;
        cur_start = 1'b0;

        // Reset and idle with start low.
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, i[0], i[1]);

        // Start edge, countdown with ignored hit/start activity.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b1, (i % 3) != 0, i == 4, i == 5);
        run_until(PH_PLAY, 8);

        // Level progression with start held high, then saturation at the top.
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1'b1, 1'b0);
        end
        run_until(PH_OVER, 40);
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);

        // Restart: hit, miss, hit, hit, then simultaneous hit+miss.
        restart_to_play();
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        run_until(PH_OVER, 40);

        // Hit coinciding with the final tick must not level up.
        restart_to_play();
        step(1'b1, 1'b1, 1'b1, 1'b0);
        n = 0;
        while (m_elapsed < GS * CPS - 1 && n < 40) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            n++;
        end
        step(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of play.
        restart_to_play();
        repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);

        // Randomized sessions with varying hit/miss/start/reset density.
        for (int r = 0; r < 25; r++) begin
            int hp, mp, len;
            hp  = $urandom_range(0, 60);
            mp  = $urandom_range(0, 40);
            len = $urandom_range(30, 70);
            for (int c = 0; c < len; c++) begin
                bit rr, ss, hh, mm;
                rr = ($urandom_range(0, 299) != 0);
                ss = ($urandom_range(0, 99) < 8) ? ~cur_start : cur_start;
                hh = ($urandom_range(0, 99) < hp);
                mm = ($urandom_range(0, 99) < mp);
                step(rr, ss, hh, mm);
            end
        end

        // Drain the scoreboard.
        @(negedge clock);
        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
